// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response channel types
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/tinyodin_pkg.sv
// rtl/tinyodin_pkg.sv - shared types and constants for the tinyODIN bus front end
package tinyodin_pkg;

    localparam int NUM_TGT = 4;
    localparam int unsigned SEL_LSB_DEF = 20;

    // Select codes match the order of the per-target port arrays.
    typedef enum logic [1:0] {
        SPIKE   = 2'd0,
        NEURON  = 2'd1,
        SYNAPSE = 2'd2,
        CONTROL = 2'd3
    } tgt_sel_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SPURIOUS = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_code_e;

    // Occupancy of the outstanding-ID FIFO seen as a state machine.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/tinyodin_id_fifo.sv
// rtl/tinyodin_id_fifo.sv - small FIFO of target IDs for granted, unanswered requests
module tinyodin_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head = mem[rd_ptr];

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; push+pop together leaves count unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tinyodin_obi_target_sched.sv
// rtl/tinyodin_obi_target_sched.sv - OBI target decode, in-order response steering and error watch
module tinyodin_obi_target_sched
    import obi_pkg::*;
    import tinyodin_pkg::*;
#(
    parameter int unsigned SEL_LSB         = SEL_LSB_DEF,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  obi_req_t   bus_req_i,
    output obi_resp_t  bus_resp_o,
    output obi_req_t   tgt_req_o [NUM_TGT],
    input  obi_resp_t  tgt_resp_i [NUM_TGT],
    output logic       busy_o,
    output logic       err_o,
    output logic [1:0] err_code_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    tgt_sel_e     sel;
    tgt_sel_e     last_id;
    tgt_sel_e     head_id;
    logic [1:0]   head_raw;
    logic [CW-1:0] count;
    sched_state_e state;
    sched_state_e state_next;
    logic         stall;
    logic         fwd;
    logic         push;
    logic         pop;
    logic         spurious;
    logic         timeout_hit;
    logic [TW-1:0] tmo_cnt;
    err_code_e    err_code;

    assign sel     = tgt_sel_e'(bus_req_i.addr[SEL_LSB +: 2]);
    assign head_id = tgt_sel_e'(head_raw);

    tinyodin_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (2)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .din    (sel),
        .head   (head_raw),
        .count  (count)
    );

    // Request steering and response return. A target switch only proceeds once
    // everything in flight has drained, so responses can never overtake each other.
    always_comb begin
        for (int t = 0; t < NUM_TGT; t++) begin
            tgt_req_o[t] = '0;
        end
        bus_resp_o = '0;
        stall = (state == ST_FULL) || ((state != ST_IDLE) && (sel != last_id));
        fwd   = rst_ni && bus_req_i.req && !stall;
        push  = fwd && tgt_resp_i[sel].gnt;
        pop   = rst_ni && (state != ST_IDLE) && tgt_resp_i[head_id].rvalid;
        if (fwd) begin
            tgt_req_o[sel]  = bus_req_i;
            bus_resp_o.gnt  = tgt_resp_i[sel].gnt;
        end
        if (state != ST_IDLE) begin
            bus_resp_o.rvalid = pop;
            bus_resp_o.rdata  = tgt_resp_i[head_id].rdata;
        end
    end

    // Error detection: rvalid from anyone but the head owner, or a stalled head.
    always_comb begin
        spurious = 1'b0;
        for (int t = 0; t < NUM_TGT; t++) begin
            if (tgt_resp_i[t].rvalid && ((state == ST_IDLE) || (t != int'(head_id)))) begin
                spurious = 1'b1;
            end
        end
        timeout_hit = (state != ST_IDLE) && !pop && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // Next occupancy state from the net push/pop change.
    always_comb begin
        state_next = state;
        if (push && !pop) begin
            state_next = (count == CW'(MAX_OUTSTANDING - 1)) ? ST_FULL : ST_ACTIVE;
        end else if (pop && !push) begin
            state_next = (count == CW'(1)) ? ST_IDLE : ST_ACTIVE;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remember the target of the newest in-flight request for the switch check.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_id <= SPIKE;
        end else if (push) begin
            last_id <= sel;
        end
    end

    // Cycles waited on the head response; holds once the limit is reached.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (pop || (state == ST_IDLE)) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Sticky error capturing only the first cause; spurious wins a tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_o    <= 1'b0;
            err_code <= ERR_NONE;
        end else if (!err_o) begin
            if (spurious) begin
                err_o    <= 1'b1;
                err_code <= ERR_SPURIOUS;
            end else if (timeout_hit) begin
                err_o    <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end
        end
    end

    assign busy_o     = (state != ST_IDLE);
    assign err_code_o = err_code;

endmodule
